// File: rtl/oserdes_ddr_gearbox.sv
// DDR output serialiser: buffers wide words in a small FIFO and plays each one
// out as BEATS pairs of WIDTH-bit lanes, one lane value per clock half.
module oserdes_ddr_gearbox #(
  parameter int unsigned         WIDTH      = 4,
  parameter int unsigned         BEATS      = 2,
  parameter int unsigned         DEPTH      = 4,
  parameter logic [WIDTH-1:0]    IDLE_VALUE = {WIDTH{1'b0}},
  localparam int unsigned        W          = 2 * WIDTH * BEATS,
  localparam int unsigned        L          = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             underrun,
  output logic [15:0]      underrun_count,
  output logic [L-1:0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [W:0]       mem [DEPTH];
  logic [W-1:0]     cur_word;
  logic             cur_last;
  logic [WIDTH-1:0] d1, d2;
  logic [WIDTH-1:0] beat_d1, beat_d2;
  logic             push, pop, load_beat, underrun_nxt;
  logic [L-1:0]     level_nxt;

  assign push      = s_valid && s_ready;
  assign level_nxt = level + L'(push) - L'(pop);

  // Serialiser next-state: pop on entry and at each word wrap, flag starvation.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pop          = 1'b0;
    load_beat    = 1'b0;
    underrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (en && (level != '0)) begin
          pop       = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        load_beat = 1'b1;
        if (cnt == CW'(BEATS - 1)) begin
          cnt_nxt = '0;
          if (en && (level != '0)) begin
            pop = 1'b1;
          end else begin
            state_nxt    = IDLE;
            underrun_nxt = en && (level == '0) && !cur_last;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the current beat's two halves from the held word.
  always_comb begin
    beat_d1 = IDLE_VALUE;
    beat_d2 = IDLE_VALUE;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (cnt == CW'(k)) begin
        beat_d1 = cur_word[(2*k)*WIDTH +: WIDTH];
        beat_d2 = cur_word[(2*k+1)*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state, beat counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      s_ready        <= 1'b1;
      busy           <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      s_ready  <= level_nxt < L'(DEPTH);
      busy     <= (state_nxt == RUN) || (level_nxt != '0);
      underrun <= underrun_nxt;
      if (underrun_nxt && (underrun_count != 16'hFFFF)) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

  // FIFO pointers, occupancy and current-word capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cur_word <= '0;
      cur_last <= 1'b0;
    end else begin
      level <= level_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        cur_word <= mem[rd_ptr][W-1:0];
        cur_last <= mem[rd_ptr][W];
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_last, s_data};
    end
  end

  // Output half registers: current beat while running, idle value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= IDLE_VALUE;
      d2 <= IDLE_VALUE;
    end else if (load_beat) begin
      d1 <= beat_d1;
      d2 <= beat_d2;
    end else begin
      d1 <= IDLE_VALUE;
      d2 <= IDLE_VALUE;
    end
  end

  // DDR mux: first half while clk is high, second half while clk is low.
  assign q = clk ? d1 : d2;

endmodule

// File: tb/tb_oserdes_ddr_gearbox.sv
// Directed bench for oserdes_ddr_gearbox with a lane-value scoreboard.
module tb_oserdes_ddr_gearbox;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned BEATS = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 2 * WIDTH * BEATS;
  localparam int unsigned L     = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [W-1:0]     s_data;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             underrun;
  logic [15:0]      underrun_count;
  logic [L-1:0]     level;

  int total = 0;
  int bad   = 0;
  int ur_pulses = 0;
  logic prev_ur = 1'b0;
  logic prev_data = 1'b0;
  logic mon_on = 1'b1;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_v;

  oserdes_ddr_gearbox #(
    .WIDTH(WIDTH), .BEATS(BEATS), .DEPTH(DEPTH), .IDLE_VALUE(4'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_last(s_last), .q(q), .busy(busy),
    .underrun(underrun), .underrun_count(underrun_count), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane monitor: sample each clock half mid-phase, compare non-idle values in order.
  initial begin
    forever begin
      @(clk);
      #2;
      if (mon_on) begin
        if (q !== 4'h0) begin
          total++;
          assert (exp_q.size() != 0) else begin
            bad++; $error("FAIL unexpected_lane: got %0h want none", q);
          end
          if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            total++;
            assert (q === exp_v) else begin
              bad++; $error("FAIL lane_value: got %0h want %0h", q, exp_v);
            end
          end
        end else if (prev_data) begin
          total++;
          assert (exp_q.size() == 0) else begin
            bad++; $error("FAIL lane_gap: got idle want %0h", exp_q[0]);
          end
        end
        prev_data = (q !== 4'h0);
      end else begin
        prev_data = 1'b0;
      end
    end
  end

  // Underrun pulse counter; a pulse must never last two cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (underrun === 1'b1) begin
        ur_pulses++;
        total++;
        assert (prev_ur === 1'b0) else begin
          bad++; $error("FAIL underrun_width: got 2+ cycles want 1");
        end
      end
      prev_ur = underrun;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++; $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 so calls can go back-to-back.
  task automatic push_word(input logic [15:0] w, input logic last);
    int t;
    t = 0;
    s_data = w; s_last = last; s_valid = 1'b1;
    while (s_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("push_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[4*k +: 4]);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); t++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ucount", 32'(underrun_count), 32'd0);
    #3 rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;

    // Single word ending a stream
    push_word(16'h4321, 1'b1);
    drain("single_drain");
    chk("single_q_idle", 32'(q), 32'h0);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_no_underrun", 32'(ur_pulses), 32'd0);

    // Two words back-to-back, no gap between them
    push_word(16'h4321, 1'b0);
    push_word(16'h8765, 1'b1);
    drain("b2b_drain");
    chk("b2b_ucount", 32'(underrun_count), 32'd0);
    chk("b2b_no_underrun", 32'(ur_pulses), 32'd0);

    // Starved stream
    push_word(16'h4321, 1'b0);
    drain("starve_drain");
    chk("starve_pulses", 32'(ur_pulses), 32'd1);
    chk("starve_ucount", 32'(underrun_count), 32'd1);
    chk("starve_q_idle", 32'(q), 32'h0);

    // Fill while disabled, refuse overflow, then drain
    en = 1'b0;
    push_word(16'h4321, 1'b0);
    push_word(16'h8765, 1'b0);
    push_word(16'hCBA9, 1'b0);
    push_word(16'h1FED, 1'b1);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    s_data = 16'h5555; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("full_refuse_level", 32'(level), 32'd4);
    chk("full_q_idle", 32'(q), 32'h0);
    en = 1'b1;
    drain("full_drain");
    chk("full_level_empty", 32'(level), 32'd0);
    chk("full_ucount", 32'(underrun_count), 32'd1);

    // Reset mid-word with two words still queued
    en = 1'b0;
    push_word(16'h4321, 1'b0);
    push_word(16'h8765, 1'b0);
    push_word(16'hCBA9, 1'b0);
    push_word(16'h1FED, 1'b1);
    en = 1'b1;
    begin
      int t;
      t = 0;
      while (level !== 3'd2 && t < 20) begin
        @(posedge clk); #1; t++;
      end
    end
    chk("mid_level", 32'(level), 32'd2);
    chk("mid_q_beat1", 32'(q), 32'h3);
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ucount", 32'(underrun_count), 32'd0);
    chk("arst_no_flag", 32'(ur_pulses), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;

    // Normal operation after reset
    push_word(16'h8765, 1'b1);
    drain("post_rst_drain");
    chk("post_rst_q_idle", 32'(q), 32'h0);
    chk("post_rst_ucount", 32'(underrun_count), 32'd0);
    chk("post_rst_pulses", 32'(ur_pulses), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
